// File: rtl/memory_access_sequencer_pkg.sv
// Shared definitions for the memory access path: MAH mode codes and sequencer states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package memory_access_sequencer_pkg;

    // Memory-address-handler access modes as issued by the control core
    localparam logic [2:0] MAH_NONE = 3'd0;
    localparam logic [2:0] MAH_PUSH = 3'd1;
    localparam logic [2:0] MAH_POP  = 3'd2;
    localparam logic [2:0] MAH_BYTE = 3'd3;
    localparam logic [2:0] MAH_HALF = 3'd4;
    localparam logic [2:0] MAH_WORD = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_INPUT    = 2'd2,
        ST_COMPLETE = 2'd3
    } state_t;

    // True for the modes that describe a real data-memory access
    function automatic logic is_mem_mode(input logic [2:0] mode);
        return (mode >= MAH_PUSH) && (mode <= MAH_WORD);
    endfunction

endpackage

// File: rtl/memory_access_sequencer_access_lane_decoder.sv
// Access lane decoder: maps MAH mode and the low address bits to byte enables and a misalignment flag.
// Latency: purely combinational.
// Backpressure: none.
module memory_access_sequencer_access_lane_decoder (
    input  logic [2:0] mode,
    input  logic [1:0] addr_lo,
    output logic [3:0] byte_en,
    output logic       misaligned
);
    import memory_access_sequencer_pkg::*;

    // Lane selection and alignment rule per access size; stack ops are word sized
    always_comb begin
        byte_en    = 4'b0000;
        misaligned = 1'b0;
        case (mode)
            MAH_BYTE: byte_en = 4'b0001 << addr_lo;
            MAH_HALF: begin
                byte_en    = 4'b0011 << addr_lo;
                misaligned = addr_lo[0];
            end
            MAH_PUSH, MAH_POP, MAH_WORD: begin
                byte_en    = 4'b1111;
                misaligned = (addr_lo != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/memory_access_sequencer.sv
// Sequences one data-memory or input-switch access per start strobe; stalls the core via enable.
// Latency: done k+1 cycles after start when mem_ready first rises at cycle k; input read 2; misaligned 1.
// Backpressure: waits in ISSUE for mem_ready; MEMORY_SEQUENCER_TIMEOUT_EN bounds that wait with a fault.
module memory_access_sequencer
    import memory_access_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            controlMAH,
    input  logic                  allow_write_on_memory,
    input  logic                  should_read_from_input_instead_of_memory,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  mem_ready,
    output logic                  mem_request,
    output logic                  mem_write_enable,
    output logic [3:0]            byte_enable,
    output logic                  sp_increment,
    output logic                  sp_decrement,
    output logic                  enable,
    output logic                  done,
    output logic                  fault,
    input  logic                  fault_clear
);

    state_t     state_q, state_d;
    logic [2:0] mode_q, mode_d;
    logic [3:0] be_q, be_d;
    logic       mem_req_q, mem_req_d;
    logic       mem_we_q, mem_we_d;
    logic       sp_inc_q, sp_inc_d;
    logic       sp_dec_q, sp_dec_d;
    logic       enable_q, enable_d;
    logic       done_q, done_d;
    logic       fault_q, fault_d;

    logic [3:0] lane_be;
    logic       lane_misaligned;
    logic       timeout_hit;

    // Upper address bits go straight to the memory; only the lane bits matter here
    logic unused_addr_hi;
    assign unused_addr_hi = ^address[ADDR_WIDTH-1:2];

`ifdef MEMORY_SEQUENCER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
`endif

    memory_access_sequencer_access_lane_decoder u_access_lane_decoder (
        .mode       (controlMAH),
        .addr_lo    (address[1:0]),
        .byte_en    (lane_be),
        .misaligned (lane_misaligned)
    );

    // Next-state and next-output logic; every output is registered from here
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        be_d     = be_q;
        mem_req_d = 1'b0;
        mem_we_d = 1'b0;
        sp_inc_d = 1'b0;
        sp_dec_d = 1'b0;
        enable_d = 1'b1;
        done_d   = 1'b0;
        // A fault raised this cycle overrides a simultaneous clear
        fault_d  = fault_q & ~fault_clear;
`ifdef MEMORY_SEQUENCER_TIMEOUT_EN
        cnt_d    = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (should_read_from_input_instead_of_memory) begin
                        state_d  = ST_INPUT;
                        mode_d   = MAH_NONE;
                        enable_d = 1'b0;
                    end else if (is_mem_mode(controlMAH)) begin
                        mode_d = controlMAH;
                        be_d   = lane_be;
                        if (lane_misaligned) begin
                            state_d = ST_COMPLETE;
                            done_d  = 1'b1;
                            fault_d = 1'b1;
                        end else begin
                            state_d   = ST_ISSUE;
                            mem_req_d = 1'b1;
                            enable_d  = 1'b0;
                            mem_we_d  = (controlMAH == MAH_PUSH) ? 1'b1 :
                                        (controlMAH == MAH_POP)  ? 1'b0 :
                                        allow_write_on_memory;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                if (mem_ready) begin
                    state_d  = ST_COMPLETE;
                    done_d   = 1'b1;
                    sp_dec_d = (mode_q == MAH_PUSH);
                    sp_inc_d = (mode_q == MAH_POP);
                end else if (timeout_hit) begin
                    state_d = ST_COMPLETE;
                    done_d  = 1'b1;
                    fault_d = 1'b1;
                end else begin
                    mem_req_d = 1'b1;
                    mem_we_d  = mem_we_q;
                    enable_d  = 1'b0;
`ifdef MEMORY_SEQUENCER_TIMEOUT_EN
                    cnt_d     = cnt_q + 1'b1;
`endif
                end
            end
            ST_INPUT: begin
                state_d = ST_COMPLETE;
                done_d  = 1'b1;
            end
            ST_COMPLETE: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset returns to idle with the core enabled
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= MAH_NONE;
            be_q      <= 4'b0000;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            sp_inc_q  <= 1'b0;
            sp_dec_q  <= 1'b0;
            enable_q  <= 1'b1;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
`ifdef MEMORY_SEQUENCER_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            be_q      <= be_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            sp_inc_q  <= sp_inc_d;
            sp_dec_q  <= sp_dec_d;
            enable_q  <= enable_d;
            done_q    <= done_d;
            fault_q   <= fault_d;
`ifdef MEMORY_SEQUENCER_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign mem_request      = mem_req_q;
    assign mem_write_enable = mem_we_q;
    assign byte_enable      = be_q;
    assign sp_increment     = sp_inc_q;
    assign sp_decrement     = sp_dec_q;
    assign enable           = enable_q;
    assign done             = done_q;
    assign fault            = fault_q;

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Bench for memory_access_sequencer: directed test-plan steps followed by random transactions.
// Expected behaviour comes from a per-transaction timeline model built from the access rules.
// Honours MEMORY_SEQUENCER_TIMEOUT_EN for the stalled-memory step.
module tb_memory_access_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  controlMAH = 3'd0;
    logic        allow_write_on_memory = 1'b0;
    logic        should_read_from_input_instead_of_memory = 1'b0;
    logic [31:0] address = 32'd0;
    logic        mem_ready = 1'b0;
    logic        fault_clear = 1'b0;
    logic        mem_request, mem_write_enable, sp_increment, sp_decrement;
    logic        enable, done, fault;
    logic [3:0]  byte_enable;

    int n_cmp = 0;
    int n_bad = 0;
    logic exp_fault = 1'b0;

    memory_access_sequencer dut (
        .clock                                   (clock),
        .reset                                   (reset),
        .start                                   (start),
        .controlMAH                              (controlMAH),
        .allow_write_on_memory                   (allow_write_on_memory),
        .should_read_from_input_instead_of_memory(should_read_from_input_instead_of_memory),
        .address                                 (address),
        .mem_ready                               (mem_ready),
        .mem_request                             (mem_request),
        .mem_write_enable                        (mem_write_enable),
        .byte_enable                             (byte_enable),
        .sp_increment                            (sp_increment),
        .sp_decrement                            (sp_decrement),
        .enable                                  (enable),
        .done                                    (done),
        .fault                                   (fault),
        .fault_clear                             (fault_clear)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Idle-state output check shared by reset and post-reset steps
    task automatic chk_idle(input string tag);
        chk({tag, ".mem_request"}, 32'(mem_request), 32'd0);
        chk({tag, ".enable"},      32'(enable),      32'd1);
        chk({tag, ".done"},        32'(done),        32'd0);
        chk({tag, ".sp_inc"},      32'(sp_increment), 32'd0);
        chk({tag, ".sp_dec"},      32'(sp_decrement), 32'd0);
        chk({tag, ".fault"},       32'(fault),       32'(exp_fault));
    endtask

    // One transaction: start in cycle 0, memory answers in cycle k; checks every cycle until idle again
    task automatic run_txn(input logic [2:0] mode, input logic wr, input logic inp,
                           input logic [31:0] addr, input int k, input logic clr_same);
        logic       valid, mis, is_mem, ewe;
        logic [3:0] ebe;
        int         last;
        valid  = inp || (mode >= 3'd1 && mode <= 3'd5);
        mis    = !inp && valid &&
                 ((mode == 3'd4 && addr[0]) ||
                  ((mode == 3'd1 || mode == 3'd2 || mode == 3'd5) && addr[1:0] != 2'd0));
        is_mem = valid && !inp && !mis;
        last   = !valid ? 3 : inp ? 2 : mis ? 1 : k + 1;
        ebe    = (mode == 3'd3) ? 4'(1 << addr[1:0]) :
                 (mode == 3'd4) ? 4'(3 << addr[1:0]) : 4'hF;
        ewe    = (mode == 3'd1) ? 1'b1 : (mode == 3'd2) ? 1'b0 : wr;

        start = 1'b1;
        controlMAH = mode;
        allow_write_on_memory = wr;
        should_read_from_input_instead_of_memory = inp;
        address = addr;
        mem_ready = 1'($urandom);
        fault_clear = clr_same;
        for (int c = 1; c <= last + 1; c++) begin
            tick();
            if (c == 1) begin
                if (mis) exp_fault = 1'b1;
                else if (clr_same) exp_fault = 1'b0;
            end
            chk("done", 32'(done), 32'(valid && c == last));
            chk("enable", 32'(enable),
                32'(is_mem ? (c > k) : inp ? (c != 1) : 1'b1));
            chk("mem_request", 32'(mem_request), 32'(is_mem && c <= k));
            if (is_mem && c <= k) begin
                chk("mem_write_enable", 32'(mem_write_enable), 32'(ewe));
                chk("byte_enable", 32'(byte_enable), 32'(ebe));
            end
            chk("sp_decrement", 32'(sp_decrement), 32'(is_mem && c == last && mode == 3'd1));
            chk("sp_increment", 32'(sp_increment), 32'(is_mem && c == last && mode == 3'd2));
            chk("fault", 32'(fault), 32'(exp_fault));
            // Inputs for cycle c: stray starts while busy must be ignored
            fault_clear = 1'b0;
            if (valid && c <= last) begin
                start = 1'($urandom);
                controlMAH = 3'($urandom);
                address = $urandom;
                allow_write_on_memory = 1'($urandom);
                should_read_from_input_instead_of_memory = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            if (is_mem) mem_ready = (c < k) ? 1'b0 : (c == k) ? 1'b1 : 1'($urandom);
            else        mem_ready = 1'($urandom);
        end
        start = 1'b0;
    endtask

    task automatic clear_fault();
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        exp_fault = 1'b0;
        chk("fault_after_clear", 32'(fault), 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst.byte_enable", 32'(byte_enable), 32'd0);
        chk("rst.mem_we", 32'(mem_write_enable), 32'd0);
        chk_idle("rst");
        reset = 1'b1;
        tick();

        // Test-plan transactions
        run_txn(3'd5, 1'b1, 1'b0, 32'h100, 3, 1'b0);  // word store, 3 ISSUE cycles
        run_txn(3'd3, 1'b0, 1'b0, 32'h203, 1, 1'b0);  // byte load, immediate ready
        run_txn(3'd1, 1'b0, 1'b0, 32'h3FC, 2, 1'b0);  // PUSH forces write
        run_txn(3'd2, 1'b1, 1'b0, 32'h3FC, 1, 1'b0);  // POP forces read
        run_txn(3'd4, 1'b0, 1'b0, 32'h101, 2, 1'b0);  // misaligned half
        clear_fault();
        run_txn(3'd0, 1'b0, 1'b1, 32'h0, 1, 1'b0);    // input-switch read
        run_txn(3'd0, 1'b1, 1'b0, 32'h10, 1, 1'b0);   // mode none: ignored
        run_txn(3'd6, 1'b1, 1'b0, 32'h10, 1, 1'b0);   // reserved mode: ignored
        run_txn(3'd5, 1'b0, 1'b0, 32'h102, 1, 1'b0);  // misaligned word
        run_txn(3'd4, 1'b0, 1'b0, 32'h003, 1, 1'b1);  // new fault beats clear
        run_txn(3'd4, 1'b1, 1'b0, 32'h002, 2, 1'b1);  // clear with good access
        run_txn(3'd4, 1'b0, 1'b0, 32'h002, 4, 1'b0);  // aligned half, upper lanes

        // Random transactions
        for (int i = 0; i < 80; i++) begin
            run_txn(3'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
                    $urandom, $urandom_range(1, 6), ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of ISSUE
        start = 1'b1; controlMAH = 3'd1; address = 32'h40;
        should_read_from_input_instead_of_memory = 1'b0; mem_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        chk("midrst.pre_mem_request", 32'(mem_request), 32'd1);
        #2 reset = 1'b0;
        #1;
        exp_fault = 1'b0;
        chk_idle("midrst");
        #2 reset = 1'b1;
        mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_idle("postrst");
        end
        mem_ready = 1'b0;

        // Memory that never answers
`ifdef MEMORY_SEQUENCER_TIMEOUT_EN
        start = 1'b1; controlMAH = 3'd2; address = 32'h80;
        for (int c = 1; c <= 17; c++) begin
            tick();
            start = 1'b0;
            if (c == 16) exp_fault = 1'b1;
            chk("to.mem_request", 32'(mem_request), 32'(c <= 15));
            chk("to.done", 32'(done), 32'(c == 16));
            chk("to.sp_inc", 32'(sp_increment), 32'd0);
            chk("to.fault", 32'(fault), 32'(exp_fault));
        end
        clear_fault();
`else
        run_txn(3'd2, 1'b0, 1'b0, 32'h80, 40, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_access_sequencer.md
Name: memory_access_sequencer

Overview:
Multi-cycle sequencer for data-memory and input-switch accesses requested by the control core (MAH modes, write enable, input-read select).
Latches one request, drives a req/ready handshake to data memory, and generates byte enables and stack-pointer adjust pulses.
Holds the core `enable` low until the access completes.
Sits between the control core and the data-memory/IO interface.

Parameters:
ADDR_WIDTH, 32, byte-address width.
TIMEOUT_CYCLES, 15, maximum cycles in ISSUE awaiting mem_ready (only with the macro enabled).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  one-cycle request strobe from the control core.
controlMAH  input  3  access mode: 1 PUSH, 2 POP, 3 byte, 4 half, 5 word, 0 none.
allow_write_on_memory  input  1  1 = store, 0 = load.
should_read_from_input_instead_of_memory  input  1  load from switches; no memory cycle.
address  input  ADDR_WIDTH  byte address, sampled with start.
mem_ready  input  1  memory completion.
mem_request  output  1  memory access active.
mem_write_enable  output  1  store qualifier, valid while mem_request=1.
byte_enable  output  4  lane enables.
sp_increment  output  1  one-cycle pulse on POP completion.
sp_decrement  output  1  one-cycle pulse on PUSH completion.
enable  output  1  core/PC enable; 0 while busy.
done  output  1  one-cycle completion pulse.
fault  output  1  sticky: misaligned access or timeout.
fault_clear  input  1  clears fault, synchronous.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; enable=1; all other outputs 0.
- States: IDLE, ISSUE, INPUT, COMPLETE.
- IDLE, start=1:
  - should_read_from_input_instead_of_memory=1 -> INPUT.
  - else controlMAH in {1..5} -> alignment check.
  - else controlMAH=0 or 6/7 -> start ignored; remain IDLE, no done.
- Alignment check (on latched address):
  - Half with address[0]=1 is misaligned.
  - Word/PUSH/POP with address[1:0]!=0 is misaligned.
  - Misaligned -> fault=1, go directly to COMPLETE, no mem_request.
- Byte enables:
  - Byte: 4'b0001<<address[1:0].
  - Half: 4'b0011<<address[1:0].
  - Word/PUSH/POP: 4'b1111.
- Registered on the start cycle: mode, write flag, byte_enable.
- ISSUE:
  - mem_request=1; mem_write_enable = write flag (PUSH forced 1, POP forced 0); enable=0.
  - Stays until mem_ready=1 sampled -> COMPLETE.
- INPUT: enable=0 for exactly one cycle -> COMPLETE.
- COMPLETE:
  - done=1, enable=1.
  - sp_decrement=1 if PUSH, sp_increment=1 if POP; neither on a faulted access.
  - mem_request=0. Next state IDLE.
- Latency:
  - start at cycle 0, mem_ready first high at cycle k>=1 -> done at cycle k+1.
  - mem_ready already high at cycle 1 -> done at cycle 2.
  - Input read -> done at cycle 2.
- enable is 0 from cycle 1 through the last ISSUE/INPUT cycle.
- start outside IDLE is ignored and not queued, including start in the COMPLETE cycle.
- mem_ready outside ISSUE is ignored.
- fault_clear=1 and a new fault in the same cycle: the fault wins, fault stays 1.
- Reset mid-access: mem_request drops immediately; no done or SP pulse is generated.

Optional Feature:
MEMORY_SEQUENCER_TIMEOUT_EN:
- Defined: a counter runs in ISSUE. After TIMEOUT_CYCLES cycles without mem_ready -> fault=1, COMPLETE, no SP pulse.
- Undefined: no counter; ISSUE waits indefinitely.

Decomposition:
- Shared package: MAH mode constants (MAH_NONE=0, PUSH=1, POP=2, BYTE=3, HALF=4, WORD=5) and state encoding typedef, reused by the control core and the memory address handler.
- One sub-module: access_lane_decoder (combinational). Maps mode + address[1:0] to byte_enable and a misaligned flag.

Test Plan:
- Word store, controlMAH=5, address=0x100, write=1, mem_ready after 3 ISSUE cycles:
  - mem_request=1 and mem_write_enable=1 for 3 cycles, byte_enable=4'b1111.
  - done at cycle 4, enable low for cycles 1-3.
- Byte load, controlMAH=3, address=0x203, mem_ready immediate -> byte_enable=4'b1000, mem_write_enable=0, done at cycle 2.
- PUSH at 0x3FC -> write access, sp_decrement pulse coincident with done. POP at 0x3FC -> read access, sp_increment pulse coincident with done.
- Half load at 0x101 -> fault=1, no mem_request, done at cycle 1 with no SP pulse; fault_clear -> fault=0 next cycle.
- Input read -> mem_request never asserted, enable=0 for exactly one cycle, done at cycle 2. Second start during ISSUE is ignored.
- Timeout, macro defined, mem_ready held 0 -> fault=1 after 15 ISSUE cycles. Reset asserted mid-ISSUE -> all outputs at reset values immediately.
